hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard detection and forwarding-select unit for the ARM-style pipeline; successor to the fixed two-stage, two-source hazard detector.
- Keeps its own shift-register scoreboard of in-flight writers over DEPTH stages, with the EXE stage at index 0.
- Per decode-stage source it returns a stall request, a forwarding-stage select and a saturating stall-cycle counter.
- Handles configurable load latency, memory freeze and branch flush.

Parameters:
- REG_W, 4, register-address width.
- NUM_SRC, 2, number of ID-stage source operands checked.
- DEPTH, 2, number of tracked stages after ID (index 0=EXE, 1=MEM, ...); must be >=1.
- LOAD_LAT, 1, first stage index at which a load result is forwardable; range 0..DEPTH, where DEPTH means loads are never forwarded.
- CNT_W, 16, stall counter width.
- Derived: SEL_W = clog2(DEPTH+1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- forward_en  in  1  forwarding enabled.
- freeze  in  1  memory stall: the whole pipeline holds.
- flush  in  1  branch taken: the ID instruction must not enter EXE.
- id_valid  in  1  the ID stage holds a real instruction.
- id_wb_en  in  1  the ID instruction writes a register.
- id_mem_r_en  in  1  the ID instruction is a load.
- id_dest  in  REG_W  the ID instruction's destination register.
- src_flat  in  NUM_SRC*REG_W  source registers; source i occupies bits [i*REG_W +: REG_W].
- src_used  in  NUM_SRC  per-source valid (replaces Two_src).
- hazard_detected  out  1  stall ID/IF and insert a bubble.
- fwd_sel_flat  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = forward from stage k.
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Reset: all entries are cleared (valid=0, dest=0, is_load=0) and stall_cnt=0. Hence hazard_detected=0 and fwd_sel_flat=0. Reset asserted mid-operation clears state immediately, asynchronously.
- Entry k holds {valid, dest, is_load}; valid is the producer's wb_en.
- Per clock, unless freeze:
  - e[k] <= e[k-1] for k = 1..DEPTH-1.
  - e[0] <= {id_wb_en, id_dest, id_mem_r_en} when id_valid & !hazard_detected & !flush; otherwise e[0] gets a bubble (valid=0).
- Freeze: every entry holds its value. Outputs are still computed from the held state.
- Register file is write-first. A producer leaving stage DEPTH-1 is readable by ID in the next cycle, so no tracking is needed beyond DEPTH-1.
- Per source i (combinational), evaluated only when id_valid & src_used[i]; otherwise the source contributes no hazard and fwd_sel=0.
  - Find the youngest k (lowest index) with e[k].valid and e[k].dest == src_i. Older matches are ignored.
  - The match is forwardable iff forward_en and (!e[k].is_load or k >= LOAD_LAT).
  - Forwardable: fwd_sel_i = k+1, no hazard from this source.
  - Not forwardable: fwd_sel_i = 0 and this source requests a hazard.
  - No match: fwd_sel_i = 0.
- hazard_detected is the OR over all sources. With forward_en=0, any valid match in any stage stalls.
- Flush does not mask hazard_detected, but it does force a bubble into e[0].
- stall_cnt increments when hazard_detected & !freeze & !flush. It saturates at all-ones and holds there. It is cleared only by rst.
- With DEPTH=2 and LOAD_LAT=1, stall decisions match the previous detector: a load in EXE stalls with forwarding on; EXE/MEM matches stall with forwarding off.

Decomposition:
- Package hazard_pkg holds:
  - the scoreboard entry struct {valid, dest, is_load};
  - the SEL_W clog2 helper;
  - the FWD_SEL_REGFILE=0 constant.
- One sub-module, hazard_src_match, instantiated NUM_SRC times. It is combinational: a youngest-match priority search over the entry vector that outputs {hazard, fwd_sel}.

Test Plan:
- Reset: run any stream, then assert rst mid-stream -> hazard_detected=0, fwd_sel_flat=0, stall_cnt=0 asynchronously. After release, the first consumer of an old dest sees no hazard.
- ALU producer: issue wb_en dest=3; next cycle src0=3, src_used=01.
  - forward_en=1 -> hazard=0, fwd_sel0=1.
  - forward_en=0 -> hazard=1 for 2 cycles (EXE then MEM), stall_cnt=2.
- Load-use, forward_en=1: load dest=5; next cycle src1=5, src_used=10.
  - Cycle 1: hazard=1, bubble into e[0].
  - Cycle 2: hazard=0, fwd_sel1=2.
  - Final stall_cnt=1.
- Youngest priority: ALU dest=2, then load dest=2; consumer reads src0=2 -> hazard=1 (load in EXE), even though MEM holds a forwardable dest=2.
- Freeze and flush:
  - Load dest=7 in EXE, consumer src0=7, freeze for 3 cycles -> hazard=1 held, entries unchanged, stall_cnt unchanged. After release, normal load-use resolution.
  - flush=1 with an issuing id_wb_en dest=4 -> next cycle a consumer of r4 sees no hazard, fwd_sel=0.
- Parameter sweep, DEPTH=3, LOAD_LAT=2, NUM_SRC=3:
  - A load is forwardable only from stage 2 (fwd_sel=3) and stalls 2 cycles.
  - src_used=000 with a matching dest -> hazard=0.
  - Force the counter to all-ones -> it saturates with CNT_W=4 at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard and its source matchers.
// Stored destinations are zero-extended to HZ_MAX_REG_W, so REG_W must not exceed it.
package hazard_pkg;

  localparam int HZ_MAX_REG_W    = 8;
  localparam int FWD_SEL_REGFILE = 0;

  typedef struct packed {
    logic                    valid;
    logic [HZ_MAX_REG_W-1:0] dest;
    logic                    is_load;
  } hz_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-match priority search of one ID source over the in-flight writer entries.
// The lowest-index match wins; a load becomes forwardable only from stage LOAD_LAT onward.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2
) (
  input  hz_entry_t [DEPTH-1:0]        entries,
  input  logic      [HZ_MAX_REG_W-1:0] src,
  input  logic                         src_en,
  input  logic                         forward_en,
  output logic                         hazard,
  output logic      [SEL_W-1:0]        fwd_sel
);

  logic found;

  always_comb begin
    hazard  = 1'b0;
    fwd_sel = SEL_W'(FWD_SEL_REGFILE);
    found   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (src_en && !found && entries[k].valid && (entries[k].dest == src)) begin
        found = 1'b1;
        if (forward_en && (!entries[k].is_load || (k >= LOAD_LAT))) begin
          fwd_sel = SEL_W'(k + 1);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding select over a DEPTH-stage scoreboard of in-flight writers.
// Entry 0 is EXE; a stalled or flushed ID instruction enters as a bubble.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = sel_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       forward_en,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic                       id_wb_en,
  input  logic                       id_mem_r_en,
  input  logic [REG_W-1:0]           id_dest,
  input  logic [NUM_SRC*REG_W-1:0]   src_flat,
  input  logic [NUM_SRC-1:0]         src_used,
  output logic                       hazard_detected,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_flat,
  output logic [CNT_W-1:0]           stall_cnt
);

  hz_entry_t [DEPTH-1:0] e_q, e_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]    src_hazard;
  logic                  issue;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [HZ_MAX_REG_W-1:0] src_ext;
    assign src_ext = HZ_MAX_REG_W'(src_flat[i*REG_W +: REG_W]);

    hazard_src_match #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .entries    (e_q),
      .src        (src_ext),
      .src_en     (id_valid & src_used[i]),
      .forward_en (forward_en),
      .hazard     (src_hazard[i]),
      .fwd_sel    (fwd_sel_flat[i*SEL_W +: SEL_W])
    );
  end

  assign hazard_detected = |src_hazard;
  assign stall_cnt       = stall_cnt_q;

  always_comb begin
    issue       = id_valid & ~hazard_detected & ~flush;
    e_d         = e_q;
    stall_cnt_d = stall_cnt_q;
    // Freeze holds every entry and the counter; outputs still reflect held state.
    if (!freeze) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        e_d[k] = e_q[k-1];
      end
      e_d[0] = '0;
      if (issue) begin
        e_d[0] = '{valid: id_wb_en, dest: HZ_MAX_REG_W'(id_dest), is_load: id_mem_r_en};
      end
      if (hazard_detected && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Two scoreboard configurations driven from one ID stream, checked against an age-list model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        forward_en = 1'b1, freeze = 1'b0, flush = 1'b0;
  logic        id_valid = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic [3:0]  id_dest = '0;
  logic [7:0]  a_src = '0;
  logic [1:0]  a_used = '0;
  logic [11:0] b_src = '0;
  logic [2:0]  b_used = '0;
  logic        a_hz, b_hz;
  logic [3:0]  a_fwd;
  logic [5:0]  b_fwd;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(4), .NUM_SRC(2), .DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .src_flat(a_src), .src_used(a_used),
    .hazard_detected(a_hz), .fwd_sel_flat(a_fwd), .stall_cnt(a_cnt));

  hazard_scoreboard #(.REG_W(4), .NUM_SRC(3), .DEPTH(3), .LOAD_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .src_flat(b_src), .src_used(b_used),
    .hazard_detected(b_hz), .fwd_sel_flat(b_fwd), .stall_cnt(b_cnt));

  typedef struct {bit v; bit [3:0] dest; bit ld;} ment_t;

  // Age lists: index 0 is the most recently entered instruction (EXE).
  ment_t h0[$];
  ment_t h1[$];
  int    mcnt[2];
  bit    exp_hz[2];
  int    exp_sel[2][3];
  int    n_pass = 0, n_total = 0;
  bit    chk_en = 1'b0;

  function automatic int dep(int d);   return d == 0 ? 2 : 3;      endfunction
  function automatic int lat(int d);   return d == 0 ? 1 : 2;      endfunction
  function automatic int nsrc(int d);  return d == 0 ? 2 : 3;      endfunction
  function automatic int cmax(int d);  return d == 0 ? 65535 : 15; endfunction

  function automatic ment_t ent(int d, int k);
    return d == 0 ? h0[k] : h1[k];
  endfunction
  function automatic int get_src(int d, int i);
    return d == 0 ? int'(a_src[i*4 +: 4]) : int'(b_src[i*4 +: 4]);
  endfunction
  function automatic bit get_used(int d, int i);
    return d == 0 ? a_used[i] : b_used[i];
  endfunction
  function automatic int act_hz(int d);
    return d == 0 ? int'(a_hz) : int'(b_hz);
  endfunction
  function automatic int act_sel(int d, int i);
    return d == 0 ? int'(a_fwd[i*2 +: 2]) : int'(b_fwd[i*2 +: 2]);
  endfunction
  function automatic int act_cnt(int d);
    return d == 0 ? int'(a_cnt) : int'(b_cnt);
  endfunction

  function automatic void calc(int d);
    ment_t e;
    exp_hz[d] = 1'b0;
    for (int i = 0; i < nsrc(d); i++) begin
      exp_sel[d][i] = 0;
      if (id_valid && get_used(d, i)) begin
        for (int k = 0; k < dep(d); k++) begin
          e = ent(d, k);
          if (e.v && int'(e.dest) == get_src(d, i)) begin
            if (forward_en && (!e.ld || k >= lat(d))) exp_sel[d][i] = k + 1;
            else exp_hz[d] = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void reset_model();
    ment_t z;
    z = '{v: 1'b0, dest: 4'd0, ld: 1'b0};
    h0.delete();
    h1.delete();
    for (int k = 0; k < 2; k++) h0.push_back(z);
    for (int k = 0; k < 3; k++) h1.push_back(z);
    mcnt[0] = 0;
    mcnt[1] = 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
  endtask

  // Compare on the falling edge, then advance the model for the coming rising edge
  // (inputs are held stable from just after one rising edge to the next).
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int d = 0; d < 2; d++) begin
        ment_t e;
        calc(d);
        chk(d == 0 ? "a_hazard" : "b_hazard", act_hz(d), int'(exp_hz[d]));
        for (int i = 0; i < nsrc(d); i++)
          chk(d == 0 ? "a_fwd_sel" : "b_fwd_sel", act_sel(d, i), exp_sel[d][i]);
        chk(d == 0 ? "a_stall_cnt" : "b_stall_cnt", act_cnt(d), mcnt[d]);
        if (!freeze) begin
          e = '{v: 1'b0, dest: 4'd0, ld: 1'b0};
          if (id_valid && !exp_hz[d] && !flush) e = '{v: id_wb_en, dest: id_dest, ld: id_mem_r_en};
          if (d == 0) begin h0.push_front(e); void'(h0.pop_back()); end
          else        begin h1.push_front(e); void'(h1.pop_back()); end
          if (exp_hz[d] && !flush && mcnt[d] < cmax(d)) mcnt[d]++;
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    #1;
    rst = 1'b0;
  endtask

  task automatic set_id(bit v, bit wb, bit ld, int dest);
    id_valid = v; id_wb_en = wb; id_mem_r_en = ld; id_dest = 4'(dest);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0);
    a_used = '0; b_used = '0; a_src = '0; b_src = '0;
    freeze = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_model();
    repeat (2) adv();
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU producer, forwarding on: forwarded from EXE.
    forward_en = 1'b1;
    set_id(1, 1, 0, 3); adv();
    set_id(1, 0, 0, 0); a_src = 8'h03; a_used = 2'b01; settle();
    chk("alu_fwd_hz", a_hz, 0);
    chk("alu_fwd_sel0", a_fwd[1:0], 1);
    adv(); idle(); adv(); adv();

    // ALU producer, forwarding off: stalls through EXE and MEM.
    do_reset(); forward_en = 1'b0;
    set_id(1, 1, 0, 3); adv();
    set_id(1, 0, 0, 0); a_src = 8'h03; a_used = 2'b01; settle();
    chk("nofwd_hz_exe", a_hz, 1);
    adv(); chk("nofwd_hz_mem", a_hz, 1);
    adv(); chk("nofwd_hz_done", a_hz, 0);
    chk("nofwd_cnt", a_cnt, 2);
    idle(); adv();

    // Load-use with forwarding: one stall, then forward from MEM.
    do_reset(); forward_en = 1'b1;
    set_id(1, 1, 1, 5); adv();
    set_id(1, 0, 0, 0); a_src = 8'h50; a_used = 2'b10; settle();
    chk("ld_use_hz1", a_hz, 1);
    chk("ld_use_sel1_c1", a_fwd[3:2], 0);
    adv();
    chk("ld_use_hz2", a_hz, 0);
    chk("ld_use_sel1_c2", a_fwd[3:2], 2);
    adv(); chk("ld_use_cnt", a_cnt, 1);
    idle(); adv();

    // Asynchronous reset mid-operation.
    forward_en = 1'b0;
    set_id(1, 1, 1, 9); adv();
    set_id(1, 0, 0, 0); a_src = 8'h09; a_used = 2'b01; settle();
    chk("pre_rst_hz", a_hz, 1);
    rst = 1'b1; reset_model(); #1;
    chk("rst_hz", a_hz, 0);
    chk("rst_fwd", a_fwd, 0);
    chk("rst_cnt", a_cnt, 0);
    rst = 1'b0; #1;
    chk("post_rst_hz", a_hz, 0);
    adv(); idle(); forward_en = 1'b1; adv();

    // Youngest match wins: load in EXE shadows forwardable ALU result in MEM.
    set_id(1, 1, 0, 2); adv();
    set_id(1, 1, 1, 2); adv();
    set_id(1, 0, 0, 0); a_src = 8'h02; a_used = 2'b01; settle();
    chk("young_hz", a_hz, 1);
    chk("young_sel0", a_fwd[1:0], 0);
    adv();
    chk("young_hz2", a_hz, 0);
    chk("young_sel0_2", a_fwd[1:0], 2);
    idle(); adv(); adv();

    // Freeze holds a load-use stall without counting.
    do_reset(); forward_en = 1'b1;
    set_id(1, 1, 1, 7); adv();
    set_id(1, 0, 0, 0); a_src = 8'h07; a_used = 2'b01; freeze = 1'b1; settle();
    chk("frz_hz", a_hz, 1);
    for (int c = 0; c < 3; c++) begin
      adv();
      chk("frz_hz_hold", a_hz, 1);
      chk("frz_cnt_hold", a_cnt, 0);
    end
    freeze = 1'b0; settle();
    chk("unfrz_hz", a_hz, 1);
    adv();
    chk("unfrz_hz2", a_hz, 0);
    chk("unfrz_sel0", a_fwd[1:0], 2);
    chk("unfrz_cnt", a_cnt, 1);
    idle(); adv();

    // Flush turns an issuing writer into a bubble.
    flush = 1'b1; set_id(1, 1, 0, 4); adv();
    flush = 1'b0; set_id(1, 0, 0, 0); a_src = 8'h04; a_used = 2'b01; settle();
    chk("flush_hz", a_hz, 0);
    chk("flush_sel0", a_fwd[1:0], 0);
    idle(); adv();

    // Wider config: load forwardable only from stage 2.
    do_reset(); forward_en = 1'b1;
    set_id(1, 1, 1, 6); adv();
    set_id(1, 0, 0, 0); b_src = 12'h600; b_used = 3'b100; settle();
    chk("b_ld_hz1", b_hz, 1);
    adv(); chk("b_ld_hz2", b_hz, 1);
    adv();
    chk("b_ld_hz3", b_hz, 0);
    chk("b_ld_sel2", b_fwd[5:4], 3);
    chk("b_ld_cnt", b_cnt, 2);
    idle(); adv();

    set_id(1, 1, 0, 6); adv();
    set_id(1, 0, 0, 0); b_src = 12'h006; b_used = 3'b000; settle();
    chk("b_unused_hz", b_hz, 0);
    chk("b_unused_fwd", b_fwd, 0);
    idle(); adv();

    // Self-dependent writer with forwarding off keeps stalling until the counter saturates.
    forward_en = 1'b0;
    set_id(1, 1, 0, 1); b_src = 12'h001; b_used = 3'b001;
    repeat (30) adv();
    chk("b_cnt_sat", b_cnt, 15);
    adv();
    chk("b_cnt_sat_hold", b_cnt, 15);
    idle(); adv();

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      forward_en  = ($urandom_range(0, 3) != 0);
      freeze      = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_wb_en    = 1'($urandom_range(0, 1));
      id_mem_r_en = ($urandom_range(0, 2) == 0);
      id_dest     = 4'($urandom_range(0, 5));
      for (int i = 0; i < 2; i++) a_src[i*4 +: 4] = 4'($urandom_range(0, 5));
      for (int i = 0; i < 3; i++) b_src[i*4 +: 4] = 4'($urandom_range(0, 5));
      a_used = 2'($urandom);
      b_used = 3'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      adv();
    end
    idle(); adv(); adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
